// File: rtl/cpu_controller_if.sv
// Handshake and datapath-control bundle between the instruction source,
// the controller and the 16-bit datapath.
interface cpu_controller_if;
    logic        start;
    logic [15:0] instr;
    logic        waiting;
    logic        illegal;
    logic [15:0] dp_imm;
    logic        wb_sel;
    logic [2:0]  w_addr;
    logic        w_en;
    logic [2:0]  r_addr;
    logic        en_A;
    logic        en_B;
    logic [1:0]  shift_op;
    logic        sel_A;
    logic        sel_B;
    logic [1:0]  ALU_op;
    logic        en_C;
    logic        en_status;

    modport master (
        output start, instr,
        input  waiting, illegal, dp_imm, wb_sel, w_addr, w_en, r_addr, en_A, en_B,
               shift_op, sel_A, sel_B, ALU_op, en_C, en_status
    );

    modport slave (
        input  start, instr,
        output waiting, illegal, dp_imm, wb_sel, w_addr, w_en, r_addr, en_A, en_B,
               shift_op, sel_A, sel_B, ALU_op, en_C, en_status
    );
endinterface

// File: rtl/cpu_controller.sv
// Moore controller sequencing the 16-bit datapath one instruction at a time.
// Outputs are registered from the next state so they always match state_q.
module cpu_controller (
    input  logic            clk,
    input  logic            rst_n,
    cpu_controller_if.slave bus
);

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_WIMM   = 3'd2,
        S_GETA   = 3'd3,
        S_GETB   = 3'd4,
        S_EXEC   = 3'd5,
        S_WB     = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        K_ILL  = 3'd0,
        K_MOVI = 3'd1,
        K_MOVR = 3'd2,
        K_ADD  = 3'd3,
        K_CMP  = 3'd4,
        K_AND  = 3'd5,
        K_MVN  = 3'd6
    } kind_t;

    typedef struct packed {
        logic        waiting;
        logic        illegal;
        logic [15:0] dp_imm;
        logic        wb_sel;
        logic [2:0]  w_addr;
        logic        w_en;
        logic [2:0]  r_addr;
        logic        en_A;
        logic        en_B;
        logic [1:0]  shift_op;
        logic        sel_A;
        logic        sel_B;
        logic [1:0]  ALU_op;
        logic        en_C;
        logic        en_status;
    } ctrl_t;

    function automatic kind_t decode_kind(input logic [15:0] ir);
        kind_t k;
        case ({ir[15:13], ir[12:11]})
            5'b110_10: k = K_MOVI;
            5'b110_00: k = K_MOVR;
            5'b101_00: k = K_ADD;
            5'b101_01: k = K_CMP;
            5'b101_10: k = K_AND;
            5'b101_11: k = K_MVN;
            default:   k = K_ILL;
        endcase
        return k;
    endfunction

    function automatic ctrl_t ctrl_for(input state_t st, input logic [15:0] ir);
        ctrl_t c;
        kind_t k;
        k        = decode_kind(ir);
        c        = '0;
        c.dp_imm = {{8{ir[7]}}, ir[7:0]};
        case (st)
            S_WAIT:   c.waiting = 1'b1;
            S_DECODE: c.illegal = (k == K_ILL);
            S_WIMM: begin
                c.wb_sel = 1'b1;
                c.w_addr = ir[10:8];
                c.w_en   = 1'b1;
            end
            S_GETA: begin
                c.r_addr = ir[10:8];
                c.en_A   = 1'b1;
            end
            S_GETB: begin
                c.r_addr = ir[2:0];
                c.en_B   = 1'b1;
            end
            S_EXEC: begin
                c.shift_op = ir[4:3];
                c.en_C     = 1'b1;
                case (k)
                    K_MOVR: c.sel_A = 1'b1;
                    K_MVN: begin
                        c.sel_A  = 1'b1;
                        c.ALU_op = 2'b11;
                    end
                    K_AND:  c.ALU_op = 2'b10;
                    K_CMP: begin
                        c.ALU_op    = 2'b01;
                        c.en_status = 1'b1;
                        c.en_C      = 1'b0;
                    end
                    default: c.ALU_op = 2'b00;
                endcase
            end
            S_WB: begin
                c.w_addr = ir[7:5];
                c.w_en   = 1'b1;
            end
            default: c.waiting = 1'b0;
        endcase
        return c;
    endfunction

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    ctrl_t       ctrl_q, ctrl_d;
    kind_t       kind_s;

    // Next-state and instruction-capture logic, plus the outputs of the next state.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        kind_s  = decode_kind(ir_q);
        case (state_q)
            S_WAIT: begin
                if (bus.start) begin
                    ir_d    = bus.instr;
                    state_d = S_DECODE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DECODE: begin
                case (kind_s)
                    K_MOVI:              state_d = S_WIMM;
                    K_MOVR, K_MVN:       state_d = S_GETB;
                    K_ADD, K_CMP, K_AND: state_d = S_GETA;
                    default:             state_d = S_WAIT;
                endcase
            end
            S_WIMM: state_d = S_WAIT;
            S_GETA: state_d = S_GETB;
            S_GETB: state_d = S_EXEC;
            S_EXEC: begin
                if (kind_s == K_CMP) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB:    state_d = S_WAIT;
            default: state_d = S_WAIT;
        endcase
        ctrl_d = ctrl_for(state_d, ir_d);
    end

    // State, instruction register and registered control outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_WAIT;
            ir_q    <= 16'h0000;
            ctrl_q  <= ctrl_for(S_WAIT, 16'h0000);
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign bus.waiting   = ctrl_q.waiting;
    assign bus.illegal   = ctrl_q.illegal;
    assign bus.dp_imm    = ctrl_q.dp_imm;
    assign bus.wb_sel    = ctrl_q.wb_sel;
    assign bus.w_addr    = ctrl_q.w_addr;
    assign bus.w_en      = ctrl_q.w_en;
    assign bus.r_addr    = ctrl_q.r_addr;
    assign bus.en_A      = ctrl_q.en_A;
    assign bus.en_B      = ctrl_q.en_B;
    assign bus.shift_op  = ctrl_q.shift_op;
    assign bus.sel_A     = ctrl_q.sel_A;
    assign bus.sel_B     = ctrl_q.sel_B;
    assign bus.ALU_op    = ctrl_q.ALU_op;
    assign bus.en_C      = ctrl_q.en_C;
    assign bus.en_status = ctrl_q.en_status;

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller, with a small behavioural datapath
// (regfile, A/B/C, shifter, ALU, Z flag) driven by the controller outputs.
module tb_cpu_controller;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    cpu_controller_if bus_if ();

    cpu_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    logic [15:0] R [8] = '{default: 16'h0000};
    logic [15:0] A_r = 16'h0000;
    logic [15:0] B_r = 16'h0000;
    logic [15:0] C_r = 16'h0000;
    logic        Z_r = 1'b0;
    logic [15:0] sh_s, ain_s, alu_s;

    function automatic logic [15:0] shf(input logic [15:0] v, input logic [1:0] s);
        case (s)
            2'b01:   return {v[14:0], 1'b0};
            2'b10:   return {1'b0, v[15:1]};
            2'b11:   return {v[15], v[15:1]};
            default: return v;
        endcase
    endfunction

    always_comb begin
        sh_s  = shf(B_r, bus_if.shift_op);
        ain_s = bus_if.sel_A ? 16'h0000 : A_r;
        case (bus_if.ALU_op)
            2'b00:   alu_s = ain_s + sh_s;
            2'b01:   alu_s = ain_s - sh_s;
            2'b10:   alu_s = ain_s & sh_s;
            default: alu_s = ~sh_s;
        endcase
    end

    // Datapath model: loads and writeback happen on the rising edge.
    always @(posedge clk) begin
        if (bus_if.en_A) A_r <= R[bus_if.r_addr];
        if (bus_if.en_B) B_r <= R[bus_if.r_addr];
        if (bus_if.en_C) C_r <= alu_s;
        if (bus_if.en_status) Z_r <= (alu_s == 16'h0000);
        if (bus_if.w_en) R[bus_if.w_addr] <= bus_if.wb_sel ? bus_if.dp_imm : C_r;
    end

    function automatic logic [4:0] en_vec();
        return {bus_if.w_en, bus_if.en_A, bus_if.en_B, bus_if.en_C, bus_if.en_status};
    endfunction

    // Issues one instruction and counts the cycles spent with waiting low.
    task automatic run_instr(input logic [15:0] ins, output int busy);
        bus_if.start = 1'b1;
        bus_if.instr = ins;
        @(negedge clk);
        bus_if.start = 1'b0;
        busy = 0;
        while (bus_if.waiting !== 1'b1 && busy < 20) begin
            busy++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_if.start = 1'b0;
        bus_if.instr = 16'h0000;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus_if.waiting !== 1'b1) begin n_bad++; $display("FAIL reset_waiting got=%b want=1", bus_if.waiting); end
        n_cmp++; if (en_vec() !== 5'b00000) begin n_bad++; $display("FAIL reset_enables got=%b want=00000", en_vec()); end
        n_cmp++; if (bus_if.illegal !== 1'b0) begin n_bad++; $display("FAIL reset_illegal got=%b want=0", bus_if.illegal); end
        n_cmp++; if ({bus_if.dp_imm, bus_if.w_addr, bus_if.r_addr} !== 22'h0) begin n_bad++; $display("FAIL reset_fields got=%h want=0", {bus_if.dp_imm, bus_if.w_addr, bus_if.r_addr}); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus_if.waiting !== 1'b1) begin n_bad++; $display("FAIL idle_waiting got=%b want=1", bus_if.waiting); end
    endtask

    task automatic test_mov_imm();
        bus_if.start = 1'b1;
        bus_if.instr = 16'hD0FB;
        @(negedge clk);
        bus_if.start = 1'b0;
        bus_if.instr = 16'h0000;
        n_cmp++; if ({bus_if.waiting, en_vec()} !== 6'b0_00000) begin n_bad++; $display("FAIL movi_decode got=%b want=000000", {bus_if.waiting, en_vec()}); end
        n_cmp++; if (bus_if.dp_imm !== 16'hFFFB) begin n_bad++; $display("FAIL movi_dp_imm got=%h want=fffb", bus_if.dp_imm); end
        @(negedge clk);
        n_cmp++; if ({en_vec(), bus_if.wb_sel, bus_if.w_addr} !== 9'b10000_1_000) begin n_bad++; $display("FAIL movi_wimm got=%b want=100001000", {en_vec(), bus_if.wb_sel, bus_if.w_addr}); end
        @(negedge clk);
        n_cmp++; if ({bus_if.waiting, en_vec()} !== 6'b1_00000) begin n_bad++; $display("FAIL movi_done got=%b want=100000", {bus_if.waiting, en_vec()}); end
        n_cmp++; if (R[0] !== 16'hFFFB) begin n_bad++; $display("FAIL movi_r0 got=%h want=fffb", R[0]); end
    endtask

    task automatic test_add();
        int busy;
        run_instr(16'hD107, busy);
        run_instr(16'hD203, busy);
        n_cmp++; if ({R[1], R[2]} !== {16'h0007, 16'h0003}) begin n_bad++; $display("FAIL add_setup got=%h want=00070003", {R[1], R[2]}); end
        bus_if.start = 1'b1;
        bus_if.instr = 16'hA16A;
        @(negedge clk);
        bus_if.start = 1'b0;
        n_cmp++; if (en_vec() !== 5'b00000) begin n_bad++; $display("FAIL add_decode got=%b want=00000", en_vec()); end
        @(negedge clk);
        n_cmp++; if ({en_vec(), bus_if.r_addr} !== 8'b01000_001) begin n_bad++; $display("FAIL add_geta got=%b want=01000001", {en_vec(), bus_if.r_addr}); end
        @(negedge clk);
        n_cmp++; if ({en_vec(), bus_if.r_addr} !== 8'b00100_010) begin n_bad++; $display("FAIL add_getb got=%b want=00100010", {en_vec(), bus_if.r_addr}); end
        @(negedge clk);
        n_cmp++; if ({en_vec(), bus_if.shift_op, bus_if.ALU_op, bus_if.sel_A, bus_if.sel_B} !== 11'b00010_01_00_00) begin n_bad++; $display("FAIL add_exec got=%b want=00010010000", {en_vec(), bus_if.shift_op, bus_if.ALU_op, bus_if.sel_A, bus_if.sel_B}); end
        @(negedge clk);
        n_cmp++; if ({en_vec(), bus_if.wb_sel, bus_if.w_addr} !== 9'b10000_0_011) begin n_bad++; $display("FAIL add_wb got=%b want=100000011", {en_vec(), bus_if.wb_sel, bus_if.w_addr}); end
        @(negedge clk);
        n_cmp++; if (bus_if.waiting !== 1'b1) begin n_bad++; $display("FAIL add_done got=%b want=1", bus_if.waiting); end
        n_cmp++; if (R[3] !== 16'd13) begin n_bad++; $display("FAIL add_r3 got=%h want=000d", R[3]); end
    endtask

    task automatic test_cmp();
        bus_if.start = 1'b1;
        bus_if.instr = 16'hA901;
        @(negedge clk);
        bus_if.start = 1'b0;
        n_cmp++; if (en_vec() !== 5'b00000) begin n_bad++; $display("FAIL cmp_decode got=%b want=00000", en_vec()); end
        @(negedge clk);
        n_cmp++; if ({en_vec(), bus_if.r_addr} !== 8'b01000_001) begin n_bad++; $display("FAIL cmp_geta got=%b want=01000001", {en_vec(), bus_if.r_addr}); end
        @(negedge clk);
        n_cmp++; if ({en_vec(), bus_if.r_addr} !== 8'b00100_001) begin n_bad++; $display("FAIL cmp_getb got=%b want=00100001", {en_vec(), bus_if.r_addr}); end
        @(negedge clk);
        n_cmp++; if ({en_vec(), bus_if.ALU_op} !== 7'b00001_01) begin n_bad++; $display("FAIL cmp_exec got=%b want=0000101", {en_vec(), bus_if.ALU_op}); end
        @(negedge clk);
        n_cmp++; if ({bus_if.waiting, en_vec()} !== 6'b1_00000) begin n_bad++; $display("FAIL cmp_done got=%b want=100000", {bus_if.waiting, en_vec()}); end
        n_cmp++; if (Z_r !== 1'b1) begin n_bad++; $display("FAIL cmp_z got=%b want=1", Z_r); end
    endtask

    task automatic test_other_ops();
        int busy;
        run_instr(16'hC081, busy);
        n_cmp++; if (busy !== 4) begin n_bad++; $display("FAIL movr_busy got=%0d want=4", busy); end
        n_cmp++; if (R[4] !== 16'h0007) begin n_bad++; $display("FAIL movr_r4 got=%h want=0007", R[4]); end
        run_instr(16'hB8A2, busy);
        n_cmp++; if (busy !== 4) begin n_bad++; $display("FAIL mvn_busy got=%0d want=4", busy); end
        n_cmp++; if (R[5] !== 16'hFFFC) begin n_bad++; $display("FAIL mvn_r5 got=%h want=fffc", R[5]); end
        run_instr(16'hB1C2, busy);
        n_cmp++; if (busy !== 5) begin n_bad++; $display("FAIL and_busy got=%0d want=5", busy); end
        n_cmp++; if (R[6] !== 16'h0003) begin n_bad++; $display("FAIL and_r6 got=%h want=0003", R[6]); end
    endtask

    task automatic test_illegal();
        int busy;
        bus_if.start = 1'b1;
        bus_if.instr = 16'hE000;
        @(negedge clk);
        bus_if.start = 1'b0;
        n_cmp++; if ({bus_if.illegal, bus_if.waiting, en_vec()} !== 7'b1_0_00000) begin n_bad++; $display("FAIL ill_decode got=%b want=1000000", {bus_if.illegal, bus_if.waiting, en_vec()}); end
        @(negedge clk);
        n_cmp++; if ({bus_if.illegal, bus_if.waiting, en_vec()} !== 7'b0_1_00000) begin n_bad++; $display("FAIL ill_done got=%b want=0100000", {bus_if.illegal, bus_if.waiting, en_vec()}); end
        run_instr(16'hC800, busy);
        n_cmp++; if (busy !== 1) begin n_bad++; $display("FAIL ill2_busy got=%0d want=1", busy); end
    endtask

    task automatic test_reset_mid();
        logic w_seen;
        bus_if.start = 1'b1;
        bus_if.instr = 16'hA1E2;
        @(negedge clk);
        bus_if.start = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (en_vec() !== 5'b00010) begin n_bad++; $display("FAIL rstmid_exec got=%b want=00010", en_vec()); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({bus_if.waiting, en_vec()} !== 6'b1_00000) begin n_bad++; $display("FAIL rstmid_abort got=%b want=100000", {bus_if.waiting, en_vec()}); end
        @(negedge clk);
        rst_n = 1'b1;
        w_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            w_seen = w_seen | bus_if.w_en;
        end
        n_cmp++; if ({w_seen, bus_if.waiting} !== 2'b01) begin n_bad++; $display("FAIL rstmid_after got=%b want=01", {w_seen, bus_if.waiting}); end
        n_cmp++; if (R[7] !== 16'h0000) begin n_bad++; $display("FAIL rstmid_r7 got=%h want=0000", R[7]); end
    endtask

    task automatic test_back_to_back();
        int busy;
        bus_if.start = 1'b1;
        bus_if.instr = 16'hA1E2;
        @(negedge clk);
        bus_if.instr = 16'hD755;
        busy = 0;
        while (bus_if.waiting !== 1'b1 && busy < 20) begin
            busy++;
            @(negedge clk);
        end
        n_cmp++; if (busy !== 5) begin n_bad++; $display("FAIL b2b_first_busy got=%0d want=5", busy); end
        n_cmp++; if (R[7] !== 16'h000A) begin n_bad++; $display("FAIL b2b_first_r7 got=%h want=000a", R[7]); end
        @(negedge clk);
        n_cmp++; if ({bus_if.waiting, bus_if.dp_imm} !== {1'b0, 16'h0055}) begin n_bad++; $display("FAIL b2b_reaccept got=%h want=00055", {bus_if.waiting, bus_if.dp_imm}); end
        bus_if.start = 1'b0;
        busy = 0;
        while (bus_if.waiting !== 1'b1 && busy < 20) begin
            busy++;
            @(negedge clk);
        end
        n_cmp++; if (busy !== 2) begin n_bad++; $display("FAIL b2b_second_busy got=%0d want=2", busy); end
        n_cmp++; if (R[7] !== 16'h0055) begin n_bad++; $display("FAIL b2b_second_r7 got=%h want=0055", R[7]); end
    endtask

    initial begin
        test_reset();
        test_mov_imm();
        test_add();
        test_cmp();
        test_other_ops();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
